// File: rtl/mod_scale_up_if.sv
// Operand/result handshake bundle for mod_scale_up.
// DATA_W defaults to the shared arbitrary-width datapath size.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

interface mod_scale_up_if #(
    parameter int DATA_W = `DATA_SIZE_ARB
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] c;

    modport master (
        output in_valid, a, q, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, q, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/mod_scale_up.sv
// Sequential pre-scaler: c = a * 2^SHIFT_BITS mod q, one double-and-subtract per clock.
// Define MODSCALE_PREREDUCE_EN to add a PRE state that folds operands in [q, 2q) first.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

// state | meaning
// IDLE  | waiting for an operand, in_ready high
// PRE   | one conditional subtract of q (MODSCALE_PREREDUCE_EN only)
// RUN   | SHIFT_BITS doublings, each reduced mod q
// DONE  | result presented, held until out_ready
module mod_scale_up #(
    parameter int DATA_W     = `DATA_SIZE_ARB,
    parameter int SHIFT_BITS = 16
) (
    input  logic          clk,
    input  logic          reset,
    mod_scale_up_if.slave bus
);

`ifdef MODSCALE_PREREDUCE_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_PRE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    localparam logic [7:0] CNT_LAST = 8'(SHIFT_BITS - 1);

    state_t            state, state_nxt;
    logic [DATA_W:0]   acc, acc_nxt;
    logic [DATA_W-1:0] q_reg, q_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [DATA_W:0]   q_ext;
    logic [DATA_W:0]   t;
    logic [DATA_W:0]   t_red;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            acc   <= '0;
            q_reg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            q_reg <= q_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // acc < q < 2^(DATA_W-1) in RUN, so the doubling never overflows DATA_W+1 bits
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        q_nxt     = q_reg;
        cnt_nxt   = cnt;
        q_ext     = {1'b0, q_reg};
        t         = acc << 1;
        t_red     = (t >= q_ext) ? (t - q_ext) : t;

        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    acc_nxt = {1'b0, bus.a};
                    q_nxt   = bus.q;
                    cnt_nxt = '0;
`ifdef MODSCALE_PREREDUCE_EN
                    state_nxt = S_PRE;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
`ifdef MODSCALE_PREREDUCE_EN
            S_PRE: begin
                if (acc >= q_ext) begin
                    acc_nxt = acc - q_ext;
                end
                state_nxt = S_RUN;
            end
`endif
            S_RUN: begin
                acc_nxt = t_red;
                cnt_nxt = cnt + 8'd1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.c         = acc[DATA_W-1:0];

endmodule

// File: tb/tb_mod_scale_up.sv
// Directed and randomized checks of mod_scale_up against an arithmetic model
// of a * 2^16 mod q, including latency, backpressure and asynchronous reset.
module tb_mod_scale_up;
    localparam int DW    = 32;
    localparam int SHIFT = 16;
`ifdef MODSCALE_PREREDUCE_EN
    localparam int LAT = SHIFT + 1;
`else
    localparam int LAT = SHIFT;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mod_scale_up_if #(.DATA_W(DW)) bus ();

    mod_scale_up #(.DATA_W(DW), .SHIFT_BITS(SHIFT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // a * 2^SHIFT fits easily in 64 bits for 32-bit operands
    function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] qv);
        longint unsigned prod;
        prod = longint'(av) << SHIFT;
        return 32'(prod % longint'(qv));
    endfunction

    // Presents an operand at the next edge, measures latency to out_valid,
    // checks the result, and checks the handshake if out_ready is high.
    task automatic run_op(input logic [31:0] av, input logic [31:0] qv,
                          input bit disturb, input logic [31:0] exp_c, input string tag);
        int cyc;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.q        = qv;
        check({tag, " in_ready_pre"}, 64'(bus.in_ready), 64'd1);
        tick();
        check({tag, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            if (disturb) begin
                bus.a = $urandom;
                bus.q = $urandom;
            end
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(LAT));
        check({tag, " c"}, 64'(bus.c), 64'(exp_c));
        if (bus.out_ready) begin
            tick();
            check({tag, " out_valid_after"}, 64'(bus.out_valid), 64'd0);
            check({tag, " in_ready_after"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] qv, av;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.q         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst c", 64'(bus.c), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // back-to-back with in_valid held high
        run_op(32'd1, 32'd7681, 1'b0, 32'd4088, "a1_q7681");
        run_op(32'd7680, 32'd7681, 1'b0, 32'd3593, "a7680");
        run_op(32'd0, 32'd7681, 1'b0, 32'd0, "a0");
        run_op(32'd1, 32'd12289, 1'b0, 32'd4091, "q12289");
        bus.in_valid = 1'b0;
        tick();

`ifdef MODSCALE_PREREDUCE_EN
        run_op(32'd7682, 32'd7681, 1'b0, 32'd4088, "prereduce");
        bus.in_valid = 1'b0;
        tick();
`endif

        // backpressure: result holds, in_valid high is not accepted
        bus.out_ready = 1'b0;
        run_op(32'd1, 32'd7681, 1'b0, 32'd4088, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp hold out_valid", 64'(bus.out_valid), 64'd1);
            check("bp hold c", 64'(bus.c), 64'd4088);
            check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp pulse out_valid", 64'(bus.out_valid), 64'd0);
        check("bp pulse in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp single out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        tick();

        // inputs scrambled every cycle while running
        run_op(32'd7680, 32'd7681, 1'b1, 32'd3593, "disturb");
        bus.in_valid = 1'b0;
        tick();

        // randomized operands checked against the arithmetic model
        for (int n = 0; n < 20; n++) begin
            qv = 32'($urandom_range(1, 32'h3FFF_FFFF)) * 32'd2 + 32'd1;
`ifdef MODSCALE_PREREDUCE_EN
            av = 32'(longint'($urandom) % (2 * longint'(qv)));
`else
            av = $urandom % qv;
`endif
            run_op(av, qv, n[0], model(av, qv), "random");
            bus.in_valid = 1'b0;
            if (n[1]) tick();
        end
        tick();

        // asynchronous reset mid-run
        bus.in_valid = 1'b1;
        bus.a        = 32'd7680;
        bus.q        = 32'd7681;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst out_valid", 64'(bus.out_valid), 64'd0);
        check("arst c", 64'(bus.c), 64'd0);
        check("arst in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_op(32'd1, 32'd7681, 1'b0, 32'd4088, "post_rst");
        bus.in_valid = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mod_scale_up.md
# mod_scale_up

Sequential modular pre-scaler: computes C = A·2^SHIFT_BITS mod q, one doubling-and-conditional-subtract per clock. It is the inverse of the word-level reduction pipeline, which divides by 2^W_SIZE per stage. It converts coefficients and twiddle factors into the reduced domain before they enter the NTT butterflies, and reuses the `DATA_SIZE_ARB datapath width. Handshaked on both sides, one operand in flight at a time.

## Interface
- DATA_W, default `DATA_SIZE_ARB: operand, modulus and result width.
- SHIFT_BITS, default 16: power of two applied (number of doublings); legal range 1..255.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block idle, accepts operand.
- a  in  DATA_W  operand; must be < q (< 2q with MODSCALE_PREREDUCE_EN).
- q  in  DATA_W  modulus; odd, 3 ≤ q < 2^(DATA_W-1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  DATA_W  result, always in [0, q).

## Operation
- States: IDLE, PRE (only with macro), RUN, DONE. Reset state: IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a into acc (DATA_W+1 bits) and q into q_reg, and clear cnt.
  - Next state is PRE with the macro, otherwise RUN.
- PRE: if acc ≥ q_reg then acc ← acc − q_reg. Next state RUN.
- RUN, each cycle:
  - t = acc<<1, in DATA_W+1 bits with no overflow, since acc < q < 2^(DATA_W-1).
  - acc ← (t ≥ q_reg) ? t − q_reg : t.
  - cnt ← cnt+1. When cnt == SHIFT_BITS−1, next state DONE.
  - cnt is 8 bits wide.
- DONE: out_valid=1, c=acc[DATA_W-1:0], held stable until out_ready. On out_valid&out_ready, go to IDLE.
- in_ready=1 only in IDLE. There is no input/output overlap, so a new operand cannot be accepted in the DONE cycle.
- a and q inputs are ignored outside the accept cycle. Changes during RUN do not affect the result.
- Operand contract violations (a out of range, q even or too large) give an undefined c, but the FSM still completes and returns to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, c=0, acc=0, q_reg=0, cnt=0, state IDLE.
- Reset asserted mid-operation aborts immediately to the above values. The operand is lost.
- Accept at edge E. out_valid rises after edge E+SHIFT_BITS, or E+SHIFT_BITS+1 with the macro.
- Result handshake at edge F: out_valid low and in_ready high after F. The earliest next accept is edge F+1.
- Throughput: one result per SHIFT_BITS+2 cycles (+1 with the macro) under a ready consumer.
- out_ready held low: out_valid and c hold indefinitely, and in_ready stays 0.
- out_ready high before DONE has no effect.

## Configuration
- MODSCALE_PREREDUCE_EN defined:
  - The PRE state exists.
  - The legal input range widens to a < 2q.
  - Latency is +1 cycle.
- Undefined:
  - No PRE state.
  - a must be < q.
  - Latency is SHIFT_BITS cycles.

## Test plan
- SHIFT_BITS=16, q=7681, a=1, out_ready=1 -> c=4088, out_valid exactly 16 cycles after accept (17 with macro), in_ready back 1 cycle after the output handshake.
- q=7681, a=7680 -> c=3593. Then a=0 -> c=0. Then q=12289, a=1 -> c=4091. Issue back-to-back, with in_valid held high throughout.
- With MODSCALE_PREREDUCE_EN: q=7681, a=7682 -> c=4088.
- Backpressure: q=7681, a=1, out_ready=0 for 10 cycles after out_valid -> c stays 4088, in_ready=0, and in_valid held high is not accepted. Then pulse out_ready -> one transfer only.
- Mid-run input disturbance: change a and q every cycle during RUN -> result unchanged from the latched operands.
- Reset: drop reset 5 cycles into RUN -> out_valid=0, c=0, in_ready=1 immediately (asynchronous). After release, a fresh operand (q=7681, a=1) yields 4088 with nominal latency.
